// File: rtl/vend_select_ctrl.sv
// vend_select_ctrl: debounced cursor selection, timed dispense control and frame-synced cursor for the renderer.
// Define VEND_SEG_EN to compile in the 7-segment drivers; without it led1..led4 are tied blank.
module vend_select_ctrl #(
    parameter int DEB_CYCLES  = 500000,
    parameter int VEND_CYCLES = 100000000
) (
    input  logic       clk_50,
    input  logic       reset_key,
    input  logic       b_left,
    input  logic       b_right,
    input  logic       start_key,
    input  logic       vsync_in,
    output logic [1:0] sel_idx,
    output logic       vend_pulse,
    output logic [1:0] vend_idx,
    output logic       busy,
    output logic [0:6] led1,
    output logic [0:6] led2,
    output logic [0:6] led3,
    output logic [0:6] led4
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int VW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
    localparam logic [VW-1:0] VEND_MAX = VW'(VEND_CYCLES - 1);

    typedef enum logic {IDLE, VEND} state_t;

    // Button bit order: 0 = left, 1 = right, 2 = start.
    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_d;
    logic [2:0]    armed;
    logic [2:0]    press;
    logic [1:0]    rdy;
    logic [DW-1:0] deb_cnt [3];

    assign btn_raw = {start_key, b_right, b_left};

    // A button only becomes armed once it has been seen released after reset,
    // so a key held through reset cannot fire until it is pressed again.
    always_ff @(posedge clk_50 or posedge reset_key) begin
        if (reset_key) begin
            sync1 <= '0;
            sync2 <= '0;
            rdy   <= '0;
            deb   <= '0;
            deb_d <= '0;
            armed <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            rdy   <= {rdy[0], 1'b1};
            deb_d <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
                if (rdy[1] && !sync2[i] && !deb[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    assign press = deb & ~deb_d & armed;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    cursor;
    logic [1:0]    cursor_nxt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] vcnt_nxt;
    logic          pulse_nxt;
    logic [1:0]    vidx_nxt;
    logic          vs1;
    logic          vs2;
    logic          vs_d;
    logic          vs_fall;

    assign vs_fall = vs_d & ~vs2;

    // Start wins over a same-cycle move; opposing moves cancel.
    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor;
        vcnt_nxt   = vcnt;
        pulse_nxt  = 1'b0;
        vidx_nxt   = vend_idx;
        case (state)
            IDLE: begin
                if (press[2]) begin
                    state_nxt = VEND;
                    vcnt_nxt  = VEND_MAX;
                    pulse_nxt = 1'b1;
                    vidx_nxt  = cursor;
                end else if (press[1] && !press[0]) begin
                    cursor_nxt = cursor + 2'd1;
                end else if (press[0] && !press[1]) begin
                    cursor_nxt = cursor - 2'd1;
                end
            end
            VEND: begin
                if (vcnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    vcnt_nxt = vcnt - VW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset_key) begin
        if (reset_key) begin
            state      <= IDLE;
            cursor     <= '0;
            vcnt       <= '0;
            vend_pulse <= 1'b0;
            vend_idx   <= '0;
            busy       <= 1'b0;
            sel_idx    <= '0;
            vs1        <= 1'b0;
            vs2        <= 1'b0;
            vs_d       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cursor     <= cursor_nxt;
            vcnt       <= vcnt_nxt;
            vend_pulse <= pulse_nxt;
            vend_idx   <= vidx_nxt;
            busy       <= (state == VEND);
            vs1        <= vsync_in;
            vs2        <= vs1;
            vs_d       <= vs2;
            if (vs_fall) begin
                sel_idx <= cursor;
            end
        end
    end

`ifdef VEND_SEG_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;

    always_ff @(posedge clk_50 or posedge reset_key) begin
        if (reset_key) begin
            bcd_tens  <= '0;
            bcd_units <= '0;
        end else if (vend_pulse) begin
            if (bcd_units == 4'd9) begin
                bcd_units <= '0;
                bcd_tens  <= (bcd_tens == 4'd9) ? 4'd0 : bcd_tens + 4'd1;
            end else begin
                bcd_units <= bcd_units + 4'd1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Displays go blank while reset is held, independent of the clock.
    always_comb begin
        led1 = 7'b1111111;
        led2 = 7'b1111111;
        led3 = 7'b1111111;
        led4 = 7'b1111111;
        if (!reset_key) begin
            led1 = seg7({2'b00, cursor} + 4'd1);
            led2 = busy ? 7'b0001100 : 7'b1111111;
            led3 = seg7(bcd_tens);
            led4 = seg7(bcd_units);
        end
    end
`else
    assign led1 = 7'b1111111;
    assign led2 = 7'b1111111;
    assign led3 = 7'b1111111;
    assign led4 = 7'b1111111;
`endif

endmodule
